// File: rtl/access_sequencer.sv
// access_sequencer: multi-cycle command sequencer in front of a single-port account RAM.
// Executes one command at a time: reads, key writes, money add/sub and a two-player transfer.
// Optional build macro ACCESS_SAT_EN: credit overflow clamps to all-ones instead of rejecting.
module access_sequencer #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned PLAYER_BITS = 2,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req,
    output logic                   ready,
    input  logic [2:0]             process,
    input  logic [PLAYER_BITS-1:0] player,
    input  logic [PLAYER_BITS-1:0] player2,
    input  logic [DATA_W-1:0]      operand,
    output logic                   done,
    output logic                   err,
    output logic [DATA_W-1:0]      result,
    output logic [PLAYER_BITS:0]   address,
    output logic [DATA_W-1:0]      data_in,
    output logic                   wren,
    input  logic [DATA_W-1:0]      q
);

    localparam int unsigned ADDR_W = PLAYER_BITS + 1;
    localparam int unsigned CNT_W  = 3;

    localparam logic [2:0] CMD_NOP    = 3'b000;
    localparam logic [2:0] CMD_RD_MON = 3'b001;
    localparam logic [2:0] CMD_RD_KEY = 3'b010;
    localparam logic [2:0] CMD_ADD    = 3'b011;
    localparam logic [2:0] CMD_SUB    = 3'b100;
    localparam logic [2:0] CMD_WR_KEY = 3'b101;
    localparam logic [2:0] CMD_XFER   = 3'b110;
    localparam logic [2:0] CMD_RSVD   = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_A, S_WAIT_A, S_RD_B, S_WAIT_B, S_CALC, S_WR_A, S_WR_B, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             cmd_q, cmd_d;
    logic [PLAYER_BITS-1:0] pa_q, pa_d, pb_q, pb_d;
    logic [DATA_W-1:0]      op_q, op_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      bal_a_q, bal_a_d, bal_b_q, bal_b_d, new_b_q, new_b_d;
    logic                   ready_q, ready_d, done_q, done_d, err_q, err_d, wren_q, wren_d;
    logic [DATA_W-1:0]      result_q, result_d, data_in_q, data_in_d;
    logic [ADDR_W-1:0]      address_q, address_d;

    logic [DATA_W:0]        sum_a, diff_a, sum_b;
    logic [DATA_W-1:0]      calc_a, calc_b;
    logic                   calc_ok;

    assign ready   = ready_q;
    assign done    = done_q;
    assign err     = err_q;
    assign result  = result_q;
    assign address = address_q;
    assign data_in = data_in_q;
    assign wren    = wren_q;

    // New balances and accept/reject decision from the captured reads.
    always_comb begin
        sum_a   = {1'b0, bal_a_q} + {1'b0, op_q};
        diff_a  = {1'b0, bal_a_q} - {1'b0, op_q};
        sum_b   = {1'b0, bal_b_q} + {1'b0, op_q};
        calc_ok = 1'b1;
        calc_a  = diff_a[DATA_W-1:0];
        calc_b  = sum_b[DATA_W-1:0];
        case (cmd_q)
            CMD_ADD: begin
                calc_a = sum_a[DATA_W-1:0];
                if (sum_a[DATA_W]) begin
`ifdef ACCESS_SAT_EN
                    calc_a = '1;
`else
                    calc_ok = 1'b0;
`endif
                end
            end
            CMD_SUB: begin
                if (diff_a[DATA_W]) calc_ok = 1'b0;
            end
            CMD_XFER: begin
                if (diff_a[DATA_W]) calc_ok = 1'b0;
                if (sum_b[DATA_W]) begin
`ifdef ACCESS_SAT_EN
                    calc_b = '1;
`else
                    calc_ok = 1'b0;
`endif
                end
            end
            default: ;
        endcase
    end

    // Next state and next registered outputs; outputs follow the state being entered.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        pa_d      = pa_q;
        pb_d      = pb_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        bal_a_d   = bal_a_q;
        bal_b_d   = bal_b_q;
        new_b_d   = new_b_q;
        address_d = address_q;
        data_in_d = data_in_q;
        result_d  = result_q;
        wren_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req && process != CMD_NOP) begin
                    cmd_d = process;
                    pa_d  = player;
                    pb_d  = player2;
                    op_d  = operand;
                    if (process == CMD_RSVD || (process == CMD_XFER && player2 == player)) begin
                        state_d  = S_DONE;
                        err_d    = 1'b1;
                        result_d = '0;
                    end else if (process == CMD_WR_KEY) begin
                        state_d   = S_WR_A;
                        wren_d    = 1'b1;
                        address_d = {player, 1'b1};
                        data_in_d = operand;
                        result_d  = operand;
                    end else begin
                        state_d   = S_RD_A;
                        address_d = {player, process == CMD_RD_KEY};
                    end
                end
            end
            S_RD_A: begin
                state_d = S_WAIT_A;
                cnt_d   = CNT_W'(RD_LAT - 1);
            end
            S_WAIT_A: begin
                if (cnt_q == '0) begin
                    bal_a_d = q;
                    if (cmd_q == CMD_RD_MON || cmd_q == CMD_RD_KEY) begin
                        state_d  = S_DONE;
                        result_d = q;
                    end else if (cmd_q == CMD_XFER) begin
                        state_d   = S_RD_B;
                        address_d = {pb_q, 1'b0};
                    end else begin
                        state_d = S_CALC;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RD_B: begin
                state_d = S_WAIT_B;
                cnt_d   = CNT_W'(RD_LAT - 1);
            end
            S_WAIT_B: begin
                if (cnt_q == '0) begin
                    bal_b_d = q;
                    state_d = S_CALC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CALC: begin
                if (!calc_ok) begin
                    state_d  = S_DONE;
                    err_d    = 1'b1;
                    result_d = bal_a_q;
                end else begin
                    state_d   = S_WR_A;
                    wren_d    = 1'b1;
                    address_d = {pa_q, 1'b0};
                    data_in_d = calc_a;
                    new_b_d   = calc_b;
                    result_d  = calc_a;
                end
            end
            S_WR_A: begin
                if (cmd_q == CMD_XFER) begin
                    state_d   = S_WR_B;
                    wren_d    = 1'b1;
                    address_d = {pb_q, 1'b0};
                    data_in_d = new_b_q;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WR_B:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        done_d  = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset drops wren and returns to IDLE immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            pa_q      <= '0;
            pb_q      <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            bal_a_q   <= '0;
            bal_b_q   <= '0;
            new_b_q   <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wren_q    <= 1'b0;
            result_q  <= '0;
            data_in_q <= '0;
            address_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            pa_q      <= pa_d;
            pb_q      <= pb_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            bal_a_q   <= bal_a_d;
            bal_b_q   <= bal_b_d;
            new_b_q   <= new_b_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wren_q    <= wren_d;
            result_q  <= result_d;
            data_in_q <= data_in_d;
            address_q <= address_d;
        end
    end

endmodule

// File: tb/tb_access_sequencer.sv
// tb_access_sequencer: table vectors, corner sequences and random commands against an account model.
module tb_access_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       req;
    logic       ready;
    logic [2:0] process;
    logic [1:0] player, player2;
    logic [7:0] operand;
    logic       done, err, wren;
    logic [7:0] result, data_in, q_r;
    logic [2:0] address;

    access_sequencer dut (
        .clock(clock), .reset(reset), .req(req), .ready(ready), .process(process),
        .player(player), .player2(player2), .operand(operand), .done(done), .err(err),
        .result(result), .address(address), .data_in(data_in), .wren(wren), .q(q_r)
    );

    always #5 clock = ~clock;

    // Account RAM, one cycle read latency; load copies the preset image.
    logic [7:0] mem [8];
    logic [7:0] init_mem [8];
    logic       load;
    always @(posedge clock) begin
        if (load) begin
            for (int i = 0; i < 8; i++) mem[i] <= init_mem[i];
        end else if (wren) begin
            mem[address] <= data_in;
        end
        q_r <= mem[address];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model of the account contents and expected command outcome.
    int exp_mem [8];
    int m_cyc, m_err, m_res, m_nw;
    int m_wa [2], m_wd [2], m_wc [2];
`ifdef ACCESS_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic add_wr(input int a, input int d, input int c);
        m_wa[m_nw] = a; m_wd[m_nw] = d; m_wc[m_nw] = c; m_nw++;
    endtask

    task automatic model(input int proc, input int p, input int p2, input int op);
        int old, dst, s;
        m_nw = 0; m_err = 0; m_res = 0;
        old = exp_mem[p*2];
        case (proc)
            1: begin m_res = old; m_cyc = 3; end
            2: begin m_res = exp_mem[p*2+1]; m_cyc = 3; end
            3: begin
                s = old + op;
                if (s > 255 && !SAT) begin m_err = 1; m_res = old; m_cyc = 4; end
                else begin
                    if (s > 255) s = 255;
                    m_res = s; add_wr(p*2, s, 4); m_cyc = 5;
                end
            end
            4: begin
                if (op > old) begin m_err = 1; m_res = old; m_cyc = 4; end
                else begin m_res = old - op; add_wr(p*2, old - op, 4); m_cyc = 5; end
            end
            5: begin m_res = op; add_wr(p*2+1, op, 1); m_cyc = 2; end
            6: begin
                if (p2 == p) begin m_err = 1; m_cyc = 1; end
                else begin
                    dst = exp_mem[p2*2];
                    s = dst + op;
                    if (op > old || (s > 255 && !SAT)) begin m_err = 1; m_res = old; m_cyc = 6; end
                    else begin
                        if (s > 255) s = 255;
                        m_res = old - op;
                        add_wr(p*2, old - op, 6);
                        add_wr(p2*2, s, 7);
                        m_cyc = 8;
                    end
                end
            end
            default: begin m_err = 1; m_cyc = 1; end
        endcase
        for (int i = 0; i < m_nw; i++) exp_mem[m_wa[i]] = m_wd[i];
    endtask

    task automatic chk_mem(input string name);
        logic [63:0] g, e;
        for (int i = 0; i < 8; i++) begin
            g[i*8 +: 8] = mem[i];
            e[i*8 +: 8] = 8'(exp_mem[i]);
        end
        chk(name, g, e);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(posedge clock); #1;
        while (!ready && n < 20) begin @(posedge clock); #1; n++; end
        if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
    endtask

    int g_cyc, g_err, g_res, g_nw;
    int g_wa [4], g_wd [4], g_wc [4];

    // Issue one command, scramble inputs after acceptance, log writes and the done cycle.
    task automatic run_cmd(input int proc, input int p, input int p2, input int op);
        bit seen = 0;
        wait_ready();
        req = 1'b1; process = 3'(proc); player = 2'(p); player2 = 2'(p2); operand = 8'(op);
        model(proc, p, p2, op);
        g_nw = 0; g_cyc = -1; g_err = -1; g_res = -1;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(posedge clock); #1;
            if (c == 1) begin
                req = 1'b0;
                process = 3'($urandom_range(1, 7));
                player = 2'($urandom); player2 = 2'($urandom); operand = 8'($urandom);
            end
            if (wren) begin
                if (g_nw < 4) begin g_wa[g_nw] = int'(address); g_wd[g_nw] = int'(data_in); g_wc[g_nw] = c; end
                g_nw++;
            end
            if (done) begin seen = 1; g_cyc = c; g_err = int'(err); g_res = int'(result); end
        end
        if (!seen) begin
            chk("done_timeout", 64'd0, 64'd1);
        end else begin
            chk("done_cycle", 64'(g_cyc), 64'(m_cyc));
            chk("err", 64'(g_err), 64'(m_err));
            chk("result", 64'(g_res), 64'(m_res));
            chk("write_count", 64'(g_nw), 64'(m_nw));
            for (int i = 0; i < m_nw && i < g_nw; i++) begin
                chk("write_addr", 64'(g_wa[i]), 64'(m_wa[i]));
                chk("write_data", 64'(g_wd[i]), 64'(m_wd[i]));
                chk("write_cycle", 64'(g_wc[i]), 64'(m_wc[i]));
            end
            chk_mem("ram");
        end
    endtask

    typedef struct {
        int proc; int p; int p2; int op;
        int cyc;  int e; int res;
    } vec_t;
    vec_t tbl [15];

    initial begin
        tbl[0]  = '{1, 0, 0, 0,   3, 0, 100};
        tbl[1]  = '{2, 2, 0, 0,   3, 0, 165};
        tbl[2]  = '{4, 0, 0, 101, 4, 1, 100};
        tbl[3]  = '{3, 0, 0, 50,  5, 0, 150};
        tbl[4]  = '{4, 0, 0, 150, 5, 0, 0};
        tbl[5]  = '{5, 3, 0, 60,  2, 0, 60};
        tbl[6]  = '{2, 3, 0, 0,   3, 0, 60};
        tbl[7]  = '{6, 1, 1, 10,  1, 1, 0};
        tbl[8]  = '{7, 2, 1, 3,   1, 1, 0};
        tbl[9]  = '{3, 0, 0, 100, 5, 0, 100};
`ifdef ACCESS_SAT_EN
        tbl[10] = '{6, 0, 1, 10,  8, 0, 90};
        tbl[11] = '{1, 1, 0, 0,   3, 0, 255};
        tbl[12] = '{3, 1, 0, 255, 5, 0, 255};
        tbl[13] = '{4, 1, 0, 0,   5, 0, 255};
`else
        tbl[10] = '{6, 0, 1, 10,  6, 1, 100};
        tbl[11] = '{1, 1, 0, 0,   3, 0, 250};
        tbl[12] = '{3, 1, 0, 255, 4, 1, 250};
        tbl[13] = '{4, 1, 0, 0,   5, 0, 250};
`endif
        tbl[14] = '{1, 2, 0, 0,   3, 0, 0};

        for (int i = 0; i < 8; i++) begin init_mem[i] = 8'h00; exp_mem[i] = 0; end
        init_mem[0] = 8'd100; exp_mem[0] = 100;
        init_mem[2] = 8'd250; exp_mem[2] = 250;
        init_mem[5] = 8'hA5;  exp_mem[5] = 165;

        reset = 1'b1; load = 1'b1; req = 1'b0;
        process = 3'd0; player = 2'd0; player2 = 2'd0; operand = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_wren", 64'(wren), 64'd0);
        chk("rst_address", 64'(address), 64'd0);
        chk("rst_data_in", 64'(data_in), 64'd0);
        load = 1'b0;
        reset = 1'b0;

        // Table-driven directed vectors.
        for (int i = 0; i < 15; i++) begin
            run_cmd(tbl[i].proc, tbl[i].p, tbl[i].p2, tbl[i].op);
            chk($sformatf("tbl%0d_cycle", i), 64'(g_cyc), 64'(tbl[i].cyc));
            chk($sformatf("tbl%0d_err", i), 64'(g_err), 64'(tbl[i].e));
            chk($sformatf("tbl%0d_result", i), 64'(g_res), 64'(tbl[i].res));
        end

        // NOP with req held: never accepted.
        begin
            int not_ready = 0, dones = 0;
            wait_ready();
            req = 1'b1; process = 3'd0;
            repeat (6) begin
                @(posedge clock); #1;
                if (!ready) not_ready++;
                if (done) dones++;
            end
            req = 1'b0;
            chk("nop_not_ready", 64'(not_ready), 64'd0);
            chk("nop_done", 64'(dones), 64'd0);
        end

        // Reset while a transfer sits in WAIT_B: nothing written.
        wait_ready();
        req = 1'b1; process = 3'd6; player = 2'd0; player2 = 2'd2; operand = 8'd5;
        repeat (4) begin @(posedge clock); #1; req = 1'b0; end
        reset = 1'b1; #1;
        chk("rstwb_wren", 64'(wren), 64'd0);
        chk("rstwb_ready_async", 64'(ready), 64'd1);
        @(posedge clock); #1; reset = 1'b0;
        @(posedge clock); #1;
        chk("rstwb_ready", 64'(ready), 64'd1);
        chk_mem("rstwb_ram");

        // Reset while wren is high (ADD in WR_A): wren drops at once, no write.
        wait_ready();
        req = 1'b1; process = 3'd3; player = 2'd3; player2 = 2'd0; operand = 8'd1;
        repeat (4) begin @(posedge clock); #1; req = 1'b0; end
        chk("rstwr_wren_before", 64'(wren), 64'd1);
        reset = 1'b1; #1;
        chk("rstwr_wren", 64'(wren), 64'd0);
        @(posedge clock); #1; reset = 1'b0;
        @(posedge clock); #1;
        chk_mem("rstwr_ram");

        // Back-to-back: second command accepted the cycle after done.
        begin
            int dcyc = -1, d2 = -1, rdy_busy = 0, rdy_after = 0, res2 = -1;
            wait_ready();
            req = 1'b1; process = 3'd1; player = 2'd0; player2 = 2'd0; operand = 8'd0;
            for (int c = 1; c <= 20 && d2 < 0; c++) begin
                @(posedge clock); #1;
                if (dcyc < 0 && ready) rdy_busy++;
                if (c == dcyc + 1 && dcyc > 0) rdy_after = int'(ready);
                if (done && dcyc < 0) begin
                    dcyc = c; process = 3'd2; player = 2'd2;
                end else if (done && dcyc > 0) begin
                    d2 = c; res2 = int'(result); req = 1'b0;
                end
            end
            req = 1'b0;
            chk("b2b_first_done", 64'(dcyc), 64'd3);
            chk("b2b_busy_ready", 64'(rdy_busy), 64'd0);
            chk("b2b_ready_after", 64'(rdy_after), 64'd1);
            chk("b2b_second_done", 64'(d2), 64'(dcyc + 4));
            chk("b2b_second_result", 64'(res2), 64'd165);
        end

        // Randomized commands against the model, operands biased to the edges.
        for (int i = 0; i < 200; i++) begin
            int sel, op;
            sel = $urandom_range(0, 3);
            op = (sel == 0) ? 0 : (sel == 1) ? 255 : int'($urandom_range(0, 255));
            run_cmd(int'($urandom_range(1, 7)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), op);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
